// File: rtl/writeback_stage.sv
// +----------------------------------------------------------------------------+
// | Module      : writeback_stage                                              |
// | Description : Final RV32I pipeline stage. Holds the MEM/WB register, waits |
// |               for the data-memory load response, aligns and extends load   |
// |               data, drives the register-file write port, exposes a WB      |
// |               forwarding tap and counts retired instructions.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   clk             pipeline clock, all state on posedge
//   rst             asynchronous active-low reset
//   mem_valid       MEM stage presents an instruction
//   wb_ready        WB accepts the MEM instruction on this posedge (combinational)
//   mem_reg_write   instruction writes rd
//   mem_rd_addr     destination register
//   mem_result_src  00 ALU, 01 load, 10 pc+4, 11 reserved (retires, no write)
//   mem_alu_result  ALU result, also the load byte address
//   mem_pc_plus4    link value for JAL/JALR
//   mem_funct3      load type
//   dmem_rvalid     load response valid (single-cycle pulse)
//   dmem_rdata      word-aligned load response word
//   WrData/WrAddress/WrEn               register-file write port (RF commits on negedge)
//   wb_fwd_valid/wb_fwd_addr/wb_fwd_data mirror of the write port
//   stall_o         WB blocked waiting for a load response
//   load_fault      1-cycle pulse: misaligned load or illegal funct3
//   instret         64-bit retired-instruction count
// Only WIDTH = 32 is supported.

`default_nettype none

module writeback_stage #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  output logic                 wb_ready,
  input  logic                 mem_reg_write,
  input  logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic [1:0]           mem_result_src,
  input  logic [WIDTH-1:0]     mem_alu_result,
  input  logic [WIDTH-1:0]     mem_pc_plus4,
  input  logic [2:0]           mem_funct3,
  input  logic                 dmem_rvalid,
  input  logic [WIDTH-1:0]     dmem_rdata,
  output logic [WIDTH-1:0]     WrData,
  output logic [ADDR_BITS-1:0] WrAddress,
  output logic                 WrEn,
  output logic                 wb_fwd_valid,
  output logic [ADDR_BITS-1:0] wb_fwd_addr,
  output logic [WIDTH-1:0]     wb_fwd_data,
  output logic                 stall_o,
  output logic                 load_fault,
  output logic [63:0]          instret
);

  localparam logic [1:0] c_SRC_ALU  = 2'b00;
  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_SRC_LINK = 2'b10;
  localparam logic [1:0] c_SRC_RSVD = 2'b11;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_FULL_ALU  = 2'd1,
    S_FULL_LOAD = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   reg_write_q;
  logic [ADDR_BITS-1:0]   rd_q;
  logic [1:0]             src_q;
  logic [WIDTH-1:0]       alu_q;
  logic [WIDTH-1:0]       pc4_q;
  logic [2:0]             funct3_q;
  logic [63:0]            instret_q;
  logic [63:0]            instret_d;

  logic                   w_complete;
  logic                   w_capture;
  logic                   w_bad_load;
  logic [1:0]             w_off;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [WIDTH-1:0]       w_load_data;
  logic [WIDTH-1:0]       w_wr_data;
  logic                   w_wr_en;

  // A held ALU-type instruction always finishes in its first cycle; a load
  // finishes on whichever cycle the response pulse shows up.
  assign w_complete = (state_q == S_FULL_ALU) ||
                      ((state_q == S_FULL_LOAD) && dmem_rvalid);
  assign wb_ready   = (state_q == S_EMPTY) || w_complete;
  assign w_capture  = mem_valid && wb_ready;
  assign stall_o    = (state_q == S_FULL_LOAD) && !dmem_rvalid;
  assign instret_d  = instret_q + 64'd1;

  // ---------------------------------------------------------------------------
  // Load alignment: pick the addressed byte / half out of the response word.
  // ---------------------------------------------------------------------------
  assign w_off = alu_q[1:0];

  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (w_off)
      2'd0: w_byte = dmem_rdata[7:0];
      2'd1: w_byte = dmem_rdata[15:8];
      2'd2: w_byte = dmem_rdata[23:16];
      2'd3: w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
  end

  assign w_half = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load_data = dmem_rdata;
    w_bad_load  = 1'b0;
    case (funct3_q)
      c_F3_LB:  w_load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      c_F3_LBU: w_load_data = {{(WIDTH-8){1'b0}}, w_byte};
      c_F3_LH: begin
        w_load_data = {{(WIDTH-16){w_half[15]}}, w_half};
        w_bad_load  = w_off[0];
      end
      c_F3_LHU: begin
        w_load_data = {{(WIDTH-16){1'b0}}, w_half};
        w_bad_load  = w_off[0];
      end
      c_F3_LW: begin
        w_load_data = dmem_rdata;
        w_bad_load  = (w_off != 2'd0);
      end
      default: begin
        // 011, 110, 111 are not RV32I loads
        w_load_data = dmem_rdata;
        w_bad_load  = 1'b1;
      end
    endcase
  end

  // Only a completing load can fault; an idle or ALU-state response is ignored.
  assign load_fault = (state_q == S_FULL_LOAD) && dmem_rvalid && w_bad_load;

  always_comb begin
    w_wr_data = alu_q;
    case (src_q)
      c_SRC_ALU:  w_wr_data = alu_q;
      c_SRC_LOAD: w_wr_data = w_load_data;
      c_SRC_LINK: w_wr_data = pc4_q;
      default:    w_wr_data = alu_q;
    endcase
  end

  // Reserved source and faulting loads still retire, they just never write.
  assign w_wr_en = w_complete && reg_write_q && (rd_q != '0) &&
                   !load_fault && (src_q != c_SRC_RSVD);

  assign WrEn         = w_wr_en;
  assign WrData       = w_wr_data;
  assign WrAddress    = rd_q;
  assign wb_fwd_valid = w_wr_en;
  assign wb_fwd_data  = w_wr_data;
  assign wb_fwd_addr  = rd_q;
  assign instret      = instret_q;

  // ---------------------------------------------------------------------------
  // State machine, MEM/WB register and retire counter.
  // Capture takes priority over the return to EMPTY so that completion and a
  // new capture on the same edge give one instruction per cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      src_q       <= c_SRC_ALU;
      alu_q       <= '0;
      pc4_q       <= '0;
      funct3_q    <= 3'b000;
      instret_q   <= 64'd0;
    end else begin
      if (w_capture) begin
        reg_write_q <= mem_reg_write;
        rd_q        <= mem_rd_addr;
        src_q       <= mem_result_src;
        alu_q       <= mem_alu_result;
        pc4_q       <= mem_pc_plus4;
        funct3_q    <= mem_funct3;
        state_q     <= (mem_result_src == c_SRC_LOAD) ? S_FULL_LOAD : S_FULL_ALU;
      end else if (w_complete) begin
        state_q <= S_EMPTY;
      end
      if (w_complete) begin
        instret_q <= instret_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_writeback_stage                                           |
// | Description : Self-checking bench for writeback_stage. A behavioural model |
// |               tracks the held instruction and retire count; every negedge  |
// |               the DUT outputs are compared against it. Directed vectors    |
// |               add literal expectations at key points.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`default_nettype none

module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        wb_ready;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [2:0]  mem_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] WrData;
  logic [4:0]  WrAddress;
  logic        WrEn;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_addr;
  logic [31:0] wb_fwd_data;
  logic        stall_o;
  logic        load_fault;
  logic [63:0] instret;

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  writeback_stage #(.WIDTH(32), .ADDR_BITS(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .wb_ready       (wb_ready),
    .mem_reg_write  (mem_reg_write),
    .mem_rd_addr    (mem_rd_addr),
    .mem_result_src (mem_result_src),
    .mem_alu_result (mem_alu_result),
    .mem_pc_plus4   (mem_pc_plus4),
    .mem_funct3     (mem_funct3),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .WrData         (WrData),
    .WrAddress      (WrAddress),
    .WrEn           (WrEn),
    .wb_fwd_valid   (wb_fwd_valid),
    .wb_fwd_addr    (wb_fwd_addr),
    .wb_fwd_data    (wb_fwd_data),
    .stall_o        (stall_o),
    .load_fault     (load_fault),
    .instret        (instret)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          valid;
    bit          load;
    bit          we;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
  } instr_t;

  instr_t      held;
  logic [63:0] m_instret;

  function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      3'b010:         return off != 2'd0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * off);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Model advance on each rising edge.
  bit m_done, m_rdy;
  always @(posedge clk) begin
    if (!rst) begin
      held      = '{1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0};
      m_instret = 64'd0;
    end else begin
      m_done = held.valid && (!held.load || dmem_rvalid);
      m_rdy  = !held.valid || m_done;
      if (m_done) m_instret = m_instret + 64'd1;
      if (mem_valid && m_rdy)
        held = '{1'b1, mem_result_src == 2'b01, mem_reg_write, mem_rd_addr,
                 mem_result_src, mem_alu_result, mem_pc_plus4, mem_funct3};
      else if (m_done)
        held.valid = 1'b0;
    end
  end

  // Compare process: one full output check every falling edge.
  bit          e_done, e_ready, e_stall, e_fault, e_wen, e_bad, e_chk;
  logic [31:0] e_data;
  logic [4:0]  e_addr;
  logic [63:0] e_inst;
  always @(negedge clk) begin
    if (started) begin
      if (!rst) begin
        e_ready = 1'b1; e_stall = 1'b0; e_fault = 1'b0; e_wen = 1'b0;
        e_data  = 32'd0; e_addr = 5'd0; e_inst = 64'd0; e_chk = 1'b1;
      end else begin
        e_done  = held.valid && (!held.load || dmem_rvalid);
        e_ready = !held.valid || e_done;
        e_stall = held.valid && held.load && !dmem_rvalid;
        e_bad   = held.load && load_bad(held.f3, held.alu[1:0]);
        e_fault = e_done && e_bad;
        e_wen   = e_done && held.we && (held.rd != 5'd0) && !e_bad && (held.src != 2'b11);
        e_data  = (held.src == 2'b01) ? load_val(held.f3, held.alu[1:0], dmem_rdata) :
                  (held.src == 2'b10) ? held.pc4 : held.alu;
        e_addr  = held.rd;
        e_inst  = m_instret;
        e_chk   = e_wen;
      end
      check("wb_ready",     {63'd0, wb_ready},     {63'd0, e_ready});
      check("stall_o",      {63'd0, stall_o},      {63'd0, e_stall});
      check("load_fault",   {63'd0, load_fault},   {63'd0, e_fault});
      check("WrEn",         {63'd0, WrEn},         {63'd0, e_wen});
      check("wb_fwd_valid", {63'd0, wb_fwd_valid}, {63'd0, e_wen});
      check("instret",      instret,               e_inst);
      if (e_chk) begin
        check("WrData",      {32'd0, WrData},      {32'd0, e_data});
        check("WrAddress",   {59'd0, WrAddress},   {59'd0, e_addr});
        check("wb_fwd_data", {32'd0, wb_fwd_data}, {32'd0, e_data});
        check("wb_fwd_addr", {59'd0, wb_fwd_addr}, {59'd0, e_addr});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [2:0] f3);
    mem_valid      = v;
    mem_reg_write  = we;
    mem_rd_addr    = rd;
    mem_result_src = src;
    mem_alu_result = alu;
    mem_pc_plus4   = pc4;
    mem_funct3     = f3;
  endtask

  // Present one load, then answer it in its entry cycle with 0x80F17F85.
  task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_fault);
    set_mem(1'b1, 1'b1, rd, 2'b01, addr, 32'd0, f3);
    tick();
    mem_valid   = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80F1_7F85;
    #1;
    check({name, ".fault"}, {63'd0, load_fault}, {63'd0, exp_fault});
    check({name, ".wren"},  {63'd0, WrEn},       {63'd0, !exp_fault});
    if (!exp_fault) check({name, ".data"}, {32'd0, WrData}, {32'd0, exp_data});
    tick();
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    set_mem(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0, 3'd0);
    @(posedge clk);
    started = 1'b1;
    #1;
    check("rst.WrEn",       {63'd0, WrEn},       64'd0);
    check("rst.WrData",     {32'd0, WrData},     64'd0);
    check("rst.WrAddress",  {59'd0, WrAddress},  64'd0);
    check("rst.stall",      {63'd0, stall_o},    64'd0);
    check("rst.load_fault", {63'd0, load_fault}, 64'd0);
    check("rst.instret",    instret,             64'd0);
    tick();
    rst = 1'b1;

    // ALU stream x5, x6, x0 back to back
    set_mem(1'b1, 1'b1, 5'd5, 2'b00, 32'h11, 32'd0, 3'd0);
    tick();
    set_mem(1'b1, 1'b1, 5'd6, 2'b00, 32'h22, 32'd0, 3'd0);
    #1;
    check("alu0.wren", {63'd0, WrEn}, 64'd1);
    check("alu0.data", {32'd0, WrData}, 64'h11);
    tick();
    set_mem(1'b1, 1'b1, 5'd0, 2'b00, 32'h33, 32'd0, 3'd0);
    #1;
    check("alu1.wren", {63'd0, WrEn}, 64'd1);
    check("alu1.addr", {59'd0, WrAddress}, 64'd6);
    check("alu1.data", {32'd0, WrData}, 64'h22);
    tick();
    mem_valid = 1'b0;
    #1;
    check("alu2.wren", {63'd0, WrEn}, 64'd0);
    check("alu2.stall", {63'd0, stall_o}, 64'd0);
    tick();
    check("alu.instret", instret, 64'd3);

    // LW x7 waits three cycles; x8 waits behind it and is taken on completion
    set_mem(1'b1, 1'b1, 5'd7, 2'b01, 32'h100, 32'd0, 3'b010);
    tick();
    set_mem(1'b1, 1'b1, 5'd8, 2'b00, 32'h55, 32'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lwait.stall", {63'd0, stall_o}, 64'd1);
      check("lwait.ready", {63'd0, wb_ready}, 64'd0);
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("lw.wren",  {63'd0, WrEn}, 64'd1);
    check("lw.addr",  {59'd0, WrAddress}, 64'd7);
    check("lw.data",  {32'd0, WrData}, 64'hDEAD_BEEF);
    check("lw.ready", {63'd0, wb_ready}, 64'd1);
    tick();
    dmem_rvalid = 1'b0;
    mem_valid   = 1'b0;
    #1;
    check("after_lw.addr", {59'd0, WrAddress}, 64'd8);
    check("after_lw.data", {32'd0, WrData}, 64'h55);
    tick();

    // Load extension and faults
    do_load("lb",   5'd10, 3'b000, 32'h200, 32'hFFFF_FF85, 1'b0);
    do_load("lbu",  5'd11, 3'b100, 32'h203, 32'h0000_0080, 1'b0);
    do_load("lh",   5'd12, 3'b001, 32'h202, 32'hFFFF_80F1, 1'b0);
    do_load("lhu",  5'd13, 3'b101, 32'h200, 32'h0000_7F85, 1'b0);
    do_load("lwmis", 5'd14, 3'b010, 32'h202, 32'd0, 1'b1);
    do_load("lhmis", 5'd15, 3'b001, 32'h201, 32'd0, 1'b1);
    do_load("f3bad", 5'd16, 3'b011, 32'h200, 32'd0, 1'b1);
    check("loads.instret", instret, 64'd12);

    // Stray response while empty
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    #1;
    check("stray.wren", {63'd0, WrEn}, 64'd0);
    tick();
    dmem_rvalid = 1'b0;

    // JAL link
    set_mem(1'b1, 1'b1, 5'd1, 2'b10, 32'h999, 32'h0000_0404, 3'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    check("jal.data",  {32'd0, WrData}, 64'h404);
    check("jal.fdata", {32'd0, wb_fwd_data}, 64'h404);
    check("jal.faddr", {59'd0, wb_fwd_addr}, 64'd1);
    check("jal.fvalid", {63'd0, wb_fwd_valid}, 64'd1);
    tick();

    // Reserved source retires without writing
    set_mem(1'b1, 1'b1, 5'd3, 2'b11, 32'h77, 32'd0, 3'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    check("rsvd.wren", {63'd0, WrEn}, 64'd0);
    tick();
    check("rsvd.instret", instret, 64'd14);

    // Reset in the middle of a load wait
    set_mem(1'b1, 1'b1, 5'd9, 2'b01, 32'h300, 32'd0, 3'b010);
    tick();
    mem_valid = 1'b0;
    #1;
    check("mrst.stall_pre", {63'd0, stall_o}, 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mrst.wren",    {63'd0, WrEn}, 64'd0);
    check("mrst.stall",   {63'd0, stall_o}, 64'd0);
    check("mrst.instret", instret, 64'd0);
    check("mrst.data",    {32'd0, WrData}, 64'd0);
    check("mrst.addr",    {59'd0, WrAddress}, 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    #1;
    check("late.wren",  {63'd0, WrEn}, 64'd0);
    check("late.stall", {63'd0, stall_o}, 64'd0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    check("late.instret", instret, 64'd0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
